// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader
//
// Read-side engine for the synchronous FIFO. Watches the FIFO status flags,
// pops words in bursts of BURST and presents them on a valid/ready stream
// with an end-of-burst marker. A 2-entry output buffer absorbs the FIFO's
// one-cycle registered read latency, so a stalled consumer never loses data.
//
// Parameters
//   ADDRW    FIFO address width (depth = 2**ADDRW)
//   DATAW    data word width
//   BURST    words per burst, 1..2**ADDRW
//   TIMEOUT  idle cycles before a partial burst is flushed (>=1); only
//            used when FIFO_BURST_READER_TIMEOUT_EN is defined
//
// Optional feature
//   FIFO_BURST_READER_TIMEOUT_EN  builds the partial-burst flush timer.
//   Without it, partial data waits in the FIFO until a full burst is there.
//
// Ports
//   i_clk        clock, rising edge
//   i_rstn       synchronous reset, active high (1 = reset)
//   i_empty      FIFO empty flag
//   i_wordcount  FIFO occupancy
//   i_rdata      FIFO read data, valid the cycle after o_rd
//   o_rd         FIFO pop request (combinational on i_empty / i_tready)
//   o_tvalid     output word valid
//   i_tready     consumer accepts the word
//   o_tdata      output word
//   o_tlast      last word of the current burst
//   o_busy       high while a burst is being read or drained

module fifo_burst_reader #(
    parameter int unsigned ADDRW   = 4,
    parameter int unsigned DATAW   = 8,
    parameter int unsigned BURST   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_empty,
    input  logic [2**ADDRW-1:0]   i_wordcount,
    input  logic [DATAW-1:0]      i_rdata,
    output logic                  o_rd,
    output logic                  o_tvalid,
    input  logic                  i_tready,
    output logic [DATAW-1:0]      o_tdata,
    output logic                  o_tlast,
    output logic                  o_busy
);

    localparam int unsigned WCW = 2**ADDRW;
    localparam int unsigned BLW = $clog2(BURST + 1);

    // Parameter range checks at elaboration
    if (BURST < 1 || BURST > WCW) begin : g_bad_burst
        $error("fifo_burst_reader: BURST must be in 1..2**ADDRW");
    end
    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("fifo_burst_reader: TIMEOUT must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BURST = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [BLW-1:0]     beats_left_q, beats_left_d;
    logic               inflight_q, inflight_d;
    logic               inflight_last_q, inflight_last_d;
    logic [1:0]         occ_q, occ_d;
    logic [DATAW-1:0]   data0_q, data0_d;
    logic [DATAW-1:0]   data1_q, data1_d;
    logic               last0_q, last0_d;
    logic               last1_q, last1_d;

`ifdef FIFO_BURST_READER_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0]      timer_q, timer_d;
`endif

    logic               pop_c;
    logic               push_c;
    logic [1:0]         pending_c;

    // Head of the output buffer drives the stream
    assign o_tvalid = (occ_q != 2'd0);
    assign o_tdata  = data0_q;
    assign o_tlast  = last0_q;
    assign o_busy   = (state_q != S_IDLE);

    // Read request: a slot is free now, or the head leaves this very cycle
    always_comb begin
        pop_c     = o_tvalid & i_tready;
        push_c    = inflight_q;
        pending_c = occ_q + 2'(inflight_q);
        o_rd      = (state_q == S_BURST) & ~i_empty & (beats_left_q != '0) &
                    ((pending_c < 2'd2) | ((pending_c == 2'd2) & pop_c));
    end

    // Next-state: burst sequencing
    always_comb begin
        state_d         = state_q;
        beats_left_d    = beats_left_q;
        inflight_d      = o_rd;
        inflight_last_d = o_rd & (beats_left_q == BLW'(1));
`ifdef FIFO_BURST_READER_TIMEOUT_EN
        timer_d         = '0;
`endif

        case (state_q)
            S_IDLE: begin
                if (i_wordcount >= WCW'(BURST)) begin
                    state_d      = S_BURST;
                    beats_left_d = BLW'(BURST);
                end
`ifdef FIFO_BURST_READER_TIMEOUT_EN
                else if (!i_empty) begin
                    // Count idle non-empty cycles; flush what is there at the limit
                    if (timer_q != TW'(TIMEOUT - 1)) begin
                        timer_d = timer_q + TW'(1);
                    end else if (i_wordcount != '0) begin
                        state_d      = S_BURST;
                        beats_left_d = BLW'(i_wordcount);
                    end else begin
                        timer_d = timer_q;
                    end
                end
`endif
            end
            S_BURST: begin
                if (o_rd) begin
                    beats_left_d = beats_left_q - BLW'(1);
                    if (beats_left_q == BLW'(1)) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (pop_c & o_tlast) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Next-state: 2-entry in-order output buffer, entry 0 is the head
    always_comb begin
        occ_d   = occ_q;
        data0_d = data0_q;
        data1_d = data1_q;
        last0_d = last0_q;
        last1_d = last1_q;

        case ({push_c, pop_c})
            2'b10: begin
                if (occ_q == 2'd0) begin
                    data0_d = i_rdata;
                    last0_d = inflight_last_q;
                end else begin
                    data1_d = i_rdata;
                    last1_d = inflight_last_q;
                end
                occ_d = occ_q + 2'd1;
            end
            2'b01: begin
                data0_d = data1_q;
                last0_d = last1_q;
                occ_d   = occ_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push and pop: occupancy unchanged, order kept
                if (occ_q == 2'd1) begin
                    data0_d = i_rdata;
                    last0_d = inflight_last_q;
                end else begin
                    data0_d = data1_q;
                    last0_d = last1_q;
                    data1_d = i_rdata;
                    last1_d = inflight_last_q;
                end
            end
            default: ;
        endcase
    end

    // State register; reset drops any word still in flight
    always_ff @(posedge i_clk) begin
        if (i_rstn) begin
            state_q         <= S_IDLE;
            beats_left_q    <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            occ_q           <= 2'd0;
            data0_q         <= '0;
            data1_q         <= '0;
            last0_q         <= 1'b0;
            last1_q         <= 1'b0;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            timer_q         <= '0;
`endif
        end else begin
            state_q         <= state_d;
            beats_left_q    <= beats_left_d;
            inflight_q      <= inflight_d;
            inflight_last_q <= inflight_last_d;
            occ_q           <= occ_d;
            data0_q         <= data0_d;
            data1_q         <= data1_d;
            last0_q         <= last0_d;
            last1_q         <= last1_d;
`ifdef FIFO_BURST_READER_TIMEOUT_EN
            timer_q         <= timer_d;
`endif
        end
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side engine for the synchronous FIFO. It watches the FIFO status outputs, pops words in bursts of BURST, and presents them on a valid/ready stream with an end-of-burst marker. It sits between the FIFO's read port (i_rd / o_rdata / o_empty / o_wordcount) and a downstream consumer. It absorbs the FIFO's one-cycle registered read latency with a 2-entry output buffer, so a stalled consumer never loses data.

## Interface
- ADDRW, default 4: FIFO address width; FIFO depth is 2**ADDRW.
- DATAW, default 8: data word width.
- BURST, default 4: words per burst, range 1..2**ADDRW.
- TIMEOUT, default 16: idle cycles before a partial burst is flushed; only used with the macro; must be ≥1.
- i_clk  in  1  the only clock; all logic on the rising edge.
- i_rstn  in  1  synchronous, active-high reset; 1 = reset.
- i_empty  in  1  FIFO empty flag.
- i_wordcount  in  2**ADDRW  FIFO occupancy.
- i_rdata  in  DATAW  FIFO read data, valid the cycle after o_rd.
- o_rd  out  1  FIFO pop request.
- o_tvalid  out  1  output word valid.
- i_tready  in  1  consumer accepts the word.
- o_tdata  out  DATAW  output word.
- o_tlast  out  1  last word of the current burst.
- o_busy  out  1  high in BURST or DRAIN.

## Operation
- States:
  - IDLE → BURST when i_wordcount ≥ BURST; load beats_left = BURST.
  - BURST → DRAIN on the cycle o_rd issues with beats_left == 1.
  - DRAIN → IDLE when the tlast word handshakes (o_tvalid & i_tready & o_tlast).
- Bursts never overlap. The next burst cannot start until the previous tlast has handshaked.
- inflight: 1-bit register, set on o_rd, cleared the next cycle. The word returned from a read is tagged last if beats_left was 1 when that read issued.
- occ: output buffer occupancy, 0..2, FIFO-ordered. Each entry holds {data, last}. The head entry drives o_tdata / o_tlast.
- o_tvalid = (occ != 0).
- Pop of the head entry on o_tvalid & i_tready.
- o_rd = (state == BURST) & ~i_empty & (beats_left != 0) & ((occ + inflight < 2) | (occ + inflight == 2 & o_tvalid & i_tready)).
  - Same-cycle credit reuse is mandatory, so sustained throughput is 1 word/cycle.
- o_rd is never asserted while i_empty = 1. If the FIFO is empty mid-burst, the block stalls in BURST until data returns.
- If a push into the buffer and a pop from it happen in the same cycle, occ is unchanged and order is preserved.
- occ + inflight never exceeds 2, so the buffer never overflows.
- beats_left is $clog2(BURST+1) bits. It decrements only on o_rd and never wraps below 0.
- Reset:
  - state = IDLE; occ = 0; inflight = 0; beats_left = 0; timer = 0.
  - Any i_rdata arriving in the cycle after reset is discarded.

## Timing
- Reset values: o_rd 0, o_tvalid 0, o_tdata 0, o_tlast 0, o_busy 0.
- Start latency: i_wordcount ≥ BURST sampled in IDLE at cycle N → BURST and o_rd at N+1 → i_rdata at N+2 → o_tvalid at N+3.
- Read latency: o_rd at cycle N → word captured at the end of N+1 → visible on o_tdata at N+2 (or later if entries ahead of it are stalled).
- o_tdata and o_tlast hold stable while o_tvalid & ~i_tready.
- o_rd depends combinationally on i_tready and i_empty. No other input-to-output paths exist.

## Configuration
- Macro: FIFO_BURST_READER_TIMEOUT_EN.
- Defined:
  - In IDLE with i_empty = 0 and i_wordcount < BURST, a timer counts up each cycle. The timer clears when i_empty = 1 or on leaving IDLE.
  - When the timer reaches TIMEOUT−1, the block enters BURST with beats_left = i_wordcount (a partial burst). Its last word carries o_tlast.
  - Timer width is $clog2(TIMEOUT+1).
- Undefined:
  - No timer logic is built.
  - Partial data waits in the FIFO until i_wordcount ≥ BURST.

## Test plan
- Reset, then push 4 words 0x11..0x14 with i_tready = 1 → one burst of 0x11..0x14, 4 consecutive valid cycles, o_tlast only on 0x14, o_busy back to 0 the cycle after.
- Push 8 words, hold i_tready = 0 for 10 cycles, then release → at most 2 o_rd pulses during the stall; words appear in order; tlast on words 4 and 8; two separate bursts.
- Push 3 words (0xA0..0xA2) with the macro defined → 16 cycles of idle, then a 3-word burst with tlast on 0xA2. With the macro undefined → no o_rd for 100 cycles.
- Push 4 words one every 3 cycles during a burst → o_rd never asserted while i_empty = 1; tlast on the 4th word; no duplicated or dropped words.
- Random i_tready (50%) over 200 words → scoreboard order matches, occ never exceeds 2, every burst is exactly 4 words.
- Assert i_rstn for 1 cycle mid-burst with occ = 2 and inflight = 1 → next cycle o_tvalid = 0, o_rd = 0, state IDLE; the in-flight word is never output.
